// File: rtl/fft_magnitude_pkg.sv
// rtl/fft_magnitude_pkg.sv - shared widths and saturation helper for the FFT power stage
// Contents:
//   AXIS_FFT_W, MAG_W, FFT_LEN_DEFAULT  stream/frame constants
//   SAMPLE_W, SQ_W, SUM_W               internal datapath widths
//   saturate_mag()                      clamp the shifted 33-bit power to MAG_W bits
package fft_magnitude_pkg;

    localparam int AXIS_FFT_W      = 32;
    localparam int MAG_W           = 24;
    localparam int FFT_LEN_DEFAULT = 1024;

    localparam int SAMPLE_W = 16;
    localparam int SQ_W     = 32;
    // One extra bit so that two full-scale squares (2^30 each) cannot wrap.
    localparam int SUM_W    = 33;

    function automatic logic [MAG_W-1:0] saturate_mag(input logic [SUM_W-1:0] value);
        if (|value[SUM_W-1:MAG_W]) begin
            return {MAG_W{1'b1}};
        end
        return value[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/fft_magnitude_mag_sq_pipe.sv
// rtl/fft_magnitude_mag_sq_pipe.sv - three-stage re^2+im^2 pipeline with a global enable
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   en                      advances all three stages together
//   in_valid, in_last       beat qualifiers entering stage 1
//   in_re, in_im            signed 16-bit bin components
//   out_data                saturated (re^2+im^2) >> SHIFT
//   out_valid, out_last     qualifiers aligned with out_data
module mag_sq_pipe
    import fft_magnitude_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic signed [SAMPLE_W-1:0] in_re,
    input  logic signed [SAMPLE_W-1:0] in_im,
    output logic [MAG_W-1:0]           out_data,
    output logic                       out_valid,
    output logic                       out_last
);

    logic                       s1_valid;
    logic                       s1_last;
    logic signed [SAMPLE_W-1:0] s1_re;
    logic signed [SAMPLE_W-1:0] s1_im;

    logic                       s2_valid;
    logic                       s2_last;
    logic [SQ_W-1:0]            s2_re_sq;
    logic [SQ_W-1:0]            s2_im_sq;

    logic signed [SQ_W-1:0]     re_sq;
    logic signed [SQ_W-1:0]     im_sq;
    logic [SUM_W-1:0]           sum;
    logic [SUM_W-1:0]           shifted;

    // Operands are sign-extended to 32 bits by the signed assignment context.
    always_comb begin
        re_sq   = s1_re * s1_re;
        im_sq   = s1_im * s1_im;
        sum     = {1'b0, s2_re_sq} + {1'b0, s2_im_sq};
        shifted = sum >> SHIFT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_re_sq <= '0;
            s2_im_sq <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_last   <= in_last;
            s1_re     <= in_re;
            s1_im     <= in_im;
            s2_valid  <= s1_valid;
            s2_last   <= s1_last;
            s2_re_sq  <= $unsigned(re_sq);
            s2_im_sq  <= $unsigned(im_sq);
            out_valid <= s2_valid;
            out_last  <= s2_last;
            out_data  <= saturate_mag(shifted);
        end
    end

endmodule

// File: rtl/fft_magnitude.sv
// rtl/fft_magnitude.sv - per-bin power of the positive-frequency half of each FFT frame
// Ports:
//   clk, reset                               rising-edge clock, synchronous active-high reset
//   din_tdata/tvalid/tready/tlast            FFT bins, tdata = {im[31:16], re[15:0]}
//   dout_tdata/tvalid/tready/tlast           unsigned 24-bit power, bins 0..FFT_LEN/2
//   frame_err                                sticky: din_tlast seen off the last bin
module fft_magnitude
    import fft_magnitude_pkg::*;
#(
    parameter int FFT_LEN = FFT_LEN_DEFAULT,
    parameter int SHIFT   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AXIS_FFT_W-1:0] din_tdata,
    input  logic                  din_tvalid,
    output logic                  din_tready,
    input  logic                  din_tlast,
    output logic [MAG_W-1:0]      dout_tdata,
    output logic                  dout_tvalid,
    input  logic                  dout_tready,
    output logic                  dout_tlast,
    output logic                  frame_err
);

    localparam int                BIN_W    = $clog2(FFT_LEN);
    localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(FFT_LEN - 1);
    localparam logic [BIN_W-1:0]  HALF_BIN = BIN_W'(FFT_LEN / 2);

    logic [BIN_W-1:0] bin;
    logic             en;
    logic             accept;
    logic             keep;
    logic             is_half;

    // A single enable stalls the whole pipeline; the input is ready whenever
    // the output register can take a new value.
    always_comb begin
        en         = dout_tready | ~dout_tvalid;
        din_tready = en;
        accept     = din_tvalid & en;
        is_half    = (bin == HALF_BIN);
        // Upper (mirror) bins are swallowed here and never occupy a stage.
        keep       = accept & (bin <= HALF_BIN);
    end

    // Any accepted last restarts the count; only the one on LAST_BIN is clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin       <= '0;
            frame_err <= 1'b0;
        end else if (accept) begin
            if (din_tlast) begin
                bin <= '0;
                if (bin != LAST_BIN) begin
                    frame_err <= 1'b1;
                end
            end else begin
                bin <= bin + 1'b1;
            end
        end
    end

    // Output last comes from the bin position only, so a premature din_tlast
    // truncates the frame without marking it.
    mag_sq_pipe #(
        .SHIFT (SHIFT)
    ) u_mag_sq_pipe (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (keep),
        .in_last   (is_half),
        .in_re     (din_tdata[SAMPLE_W-1:0]),
        .in_im     (din_tdata[AXIS_FFT_W-1:SAMPLE_W]),
        .out_data  (dout_tdata),
        .out_valid (dout_tvalid),
        .out_last  (dout_tlast)
    );

endmodule

// File: tb/tb_fft_magnitude.sv
// tb/tb_fft_magnitude.sv - self-checking bench for fft_magnitude
module tb_fft_magnitude;

    localparam int L = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] din_tdata = '0;
    logic        din_tvalid = 1'b0;
    logic        din_tlast = 1'b0;
    logic        dout_tready = 1'b1;

    logic        din_tready;
    logic [23:0] dout_tdata;
    logic        dout_tvalid;
    logic        dout_tlast;
    logic        frame_err;

    logic        sh8_din_tready;
    logic [23:0] sh8_tdata;
    logic        sh8_tvalid;
    logic        sh8_tlast;
    logic        sh8_frame_err;

    fft_magnitude #(.FFT_LEN(L), .SHIFT(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .din_tdata   (din_tdata),
        .din_tvalid  (din_tvalid),
        .din_tready  (din_tready),
        .din_tlast   (din_tlast),
        .dout_tdata  (dout_tdata),
        .dout_tvalid (dout_tvalid),
        .dout_tready (dout_tready),
        .dout_tlast  (dout_tlast),
        .frame_err   (frame_err)
    );

    fft_magnitude #(.FFT_LEN(L), .SHIFT(8)) dut_sh8 (
        .clk         (clk),
        .reset       (reset),
        .din_tdata   (din_tdata),
        .din_tvalid  (din_tvalid),
        .din_tready  (sh8_din_tready),
        .din_tlast   (din_tlast),
        .dout_tdata  (sh8_tdata),
        .dout_tvalid (sh8_tvalid),
        .dout_tready (dout_tready),
        .dout_tlast  (sh8_tlast),
        .frame_err   (sh8_frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] d0;
        logic [23:0] d1;
        logic        last;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [23:0] d0;
        logic [23:0] d1;
        logic        l0;
        logic        l1;
        logic        v1;
        int          cyc;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   model_bin = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   ready_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset === 1'b0 && dout_tvalid === 1'b1 && dout_tready === 1'b1) begin
            obs_t o;
            o.d0  = dout_tdata;
            o.d1  = sh8_tdata;
            o.l0  = dout_tlast;
            o.l1  = sh8_tlast;
            o.v1  = sh8_tvalid;
            o.cyc = cyc;
            obs_q.push_back(o);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) dout_tready = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference: power from plain integer arithmetic, frame rules from bin position.
    function automatic logic [23:0] power(input logic [15:0] re, input logic [15:0] im, input int shift);
        longint r = $signed(re);
        longint i = $signed(im);
        longint p = (r * r + i * i) >> shift;
        if (p >= 64'd16777216) return 24'hFFFFFF;
        return p[23:0];
    endfunction

    function automatic void model_accept(input logic [15:0] re, input logic [15:0] im, input logic last);
        exp_t e;
        if (model_bin <= L / 2) begin
            e.d0   = power(re, im, 0);
            e.d1   = power(re, im, 8);
            e.last = (model_bin == L / 2);
            e.cyc  = cyc;
            exp_q.push_back(e);
        end
        if (last) model_bin = 0;
        else model_bin = (model_bin + 1) % L;
    endfunction

    task automatic send_beat(input logic [15:0] re, input logic [15:0] im, input logic last);
        int n = 0;
        bit done = 1'b0;
        din_tdata  = {im, re};
        din_tlast  = last;
        din_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (din_tready === 1'b1) begin
                model_accept(re, im, last);
                done = 1'b1;
            end else if (n++ > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: din_tready=%b required 1", din_tready);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        din_tvalid = 1'b0;
        din_tlast  = 1'b0;
    endtask

    task automatic drain();
        dout_tready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        dout_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dout_tvalid, dout_tlast, frame_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: valid/last/err=%b%b%b required 000", dout_tvalid, dout_tlast, frame_err);
        end
        checks++;
        if (dout_tdata !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 000000", dout_tdata);
        end
        checks++;
        if (din_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", din_tready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (din_tready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b required 1", din_tready);
        end
        @(posedge clk);
        #1;
        dout_tready = 1'b1;
    endtask

    task automatic test_ramp();
        for (int k = 0; k < L; k++) send_beat(16'(k), 16'h0, k == L - 1);
        drain();
        checks++;
        if (obs_q.size() != 5) begin
            errors++;
            $display("FAIL ramp_count: got %0d required 5", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 5 && i < exp_q.size(); i++) begin
            logic [23:0] want;
            want = 24'(i * i);
            checks++;
            if (obs_q[i].d0 !== want || obs_q[i].l0 !== (i == 4)) begin
                errors++;
                $display("FAIL ramp_beat[%0d]: got %h last=%b required %h last=%b", i, obs_q[i].d0, obs_q[i].l0, want, i == 4);
            end
            checks++;
            if (obs_q[i].cyc - exp_q[i].cyc != 3) begin
                errors++;
                $display("FAIL ramp_latency[%0d]: got %0d required 3", i, obs_q[i].cyc - exp_q[i].cyc);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_extreme();
        for (int k = 0; k < L; k++) send_beat(16'h8000, 16'h8000, k == L - 1);
        drain();
        checks++;
        if (obs_q.size() != 5) begin
            errors++;
            $display("FAIL extreme_count: got %0d required 5", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].d1 !== 24'h800000) begin
                errors++;
                $display("FAIL extreme_shift8: got %h required 800000", obs_q[0].d1);
            end
            checks++;
            if (obs_q[0].d0 !== 24'hFFFFFF) begin
                errors++;
                $display("FAIL extreme_sat: got %h required ffffff", obs_q[0].d0);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stall();
        fork
            begin
                for (int k = 0; k < L; k++) send_beat(16'($urandom), 16'($urandom), k == L - 1);
            end
            begin
                int n = 0;
                logic [23:0] hd;
                logic        hl;
                while (obs_q.size() < 2 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 200) begin
                    checks++;
                    errors++;
                    $display("FAIL stall_wait: outputs=%0d required 2", obs_q.size());
                end
                @(posedge clk);
                #1;
                dout_tready = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    @(negedge clk);
                    checks++;
                    if (dout_tvalid !== 1'b1 || din_tready !== 1'b0 || sh8_din_tready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_flags[%0d]: valid=%b ready=%b/%b required 1 0/0", s, dout_tvalid, din_tready, sh8_din_tready);
                    end
                    if (s == 0) begin
                        hd = dout_tdata;
                        hl = dout_tlast;
                    end else begin
                        checks++;
                        if (dout_tdata !== hd || dout_tlast !== hl) begin
                            errors++;
                            $display("FAIL stall_hold[%0d]: got %h/%b required %h/%b", s, dout_tdata, dout_tlast, hd, hl);
                        end
                    end
                end
                @(posedge clk);
                #1;
                dout_tready = 1'b1;
            end
        join
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k].d0 !== exp_q[k].d0 || obs_q[k].d1 !== exp_q[k].d1 || obs_q[k].l0 !== exp_q[k].last) begin
                errors++;
                $display("FAIL stall_beat[%0d]: got %h %h %b required %h %h %b", k, obs_q[k].d0, obs_q[k].d1, obs_q[k].l0, exp_q[k].d0, exp_q[k].d1, exp_q[k].last);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        ready_mode = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < L; b++) begin
                logic [15:0] re;
                logic [15:0] im;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                re = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                im = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
                send_beat(re, im, b == L - 1);
            end
        end
        ready_mode = 1'b0;
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k].d0 !== exp_q[k].d0 || obs_q[k].d1 !== exp_q[k].d1 || obs_q[k].l0 !== exp_q[k].last
                || obs_q[k].l1 !== exp_q[k].last || obs_q[k].v1 !== 1'b1) begin
                errors++;
                $display("FAIL random_beat[%0d]: got %h %h %b/%b v=%b required %h %h %b", k, obs_q[k].d0, obs_q[k].d1,
                         obs_q[k].l0, obs_q[k].l1, obs_q[k].v1, exp_q[k].d0, exp_q[k].d1, exp_q[k].last);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_misaligned();
        for (int k = 0; k < 4; k++) send_beat(16'($urandom), 16'($urandom), k == 3);
        checks++;
        if (frame_err !== 1'b1 || sh8_frame_err !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_err: got %b/%b required 1/1", frame_err, sh8_frame_err);
        end
        for (int k = 0; k < L; k++) send_beat(16'($urandom), 16'($urandom), k == L - 1);
        drain();
        checks++;
        if (obs_q.size() != 9 || exp_q.size() != 9) begin
            errors++;
            $display("FAIL misaligned_count: got %0d required 9", obs_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k].d0 !== exp_q[k].d0 || obs_q[k].d1 !== exp_q[k].d1 || obs_q[k].l0 !== exp_q[k].last) begin
                errors++;
                $display("FAIL misaligned_beat[%0d]: got %h %h %b required %h %h %b", k, obs_q[k].d0, obs_q[k].d1, obs_q[k].l0, exp_q[k].d0, exp_q[k].d1, exp_q[k].last);
            end
        end
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_sticky: got %b required 1", frame_err);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) send_beat(16'($urandom), 16'($urandom), 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dout_tvalid !== 1'b0 || frame_err !== 1'b0 || din_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: valid=%b err=%b ready=%b required 0 0 1", dout_tvalid, frame_err, din_tready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        model_bin = 0;
        for (int k = 0; k < L; k++) send_beat(16'($urandom), 16'($urandom), k == L - 1);
        drain();
        checks++;
        if (obs_q.size() != 5 || exp_q.size() != 5) begin
            errors++;
            $display("FAIL reset_mid_count: got %0d required 5", obs_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k].d0 !== exp_q[k].d0 || obs_q[k].d1 !== exp_q[k].d1 || obs_q[k].l0 !== exp_q[k].last) begin
                errors++;
                $display("FAIL reset_mid_beat[%0d]: got %h %h %b required %h %h %b", k, obs_q[k].d0, obs_q[k].d1, obs_q[k].l0, exp_q[k].d0, exp_q[k].d1, exp_q[k].last);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_extreme();
        test_stall();
        test_random();
        test_misaligned();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_magnitude.md
FFT_MAGNITUDE -- requirements
Module: fft_magnitude

Interface
REQ-001 Parameter FFT_LEN, default 1024, meaning complex bins per FFT frame; power of two, 8..4096.
REQ-002 Parameter SHIFT, default 8, meaning right-shift applied to the 33-bit squared magnitude before saturation to 24 bits.
REQ-003 Port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port din  Axis_If.Slave  32 data + valid/ready/last  FFT output bins; data = {im[31:16], re[15:0]}, both two's-complement.
REQ-006 Port dout  Axis_IF.Master  24 data + valid/ready/last  unsigned per-bin power, feeding the peakiness stage.
REQ-007 Port frame_err  output  1  sticky flag: din.last was misaligned with the bin count.

Function
REQ-008 The block SHALL compute p = (re*re + im*im) >> SHIFT as an unsigned 33-bit value before the shift.
REQ-009 dout.data SHALL be p saturated to 24'hFFFFFF when p >= 2^24.
REQ-010 The datapath SHALL be a 3-stage pipeline: S1 register re/im, S2 register both squares, S3 add/shift/saturate into the output register.
REQ-011 Latency from an accepted input beat to its dout.valid SHALL be 3 cycles when dout.ready stays high.
REQ-012 A single enable, en = dout.ready OR NOT dout.valid, SHALL advance all stages together.
REQ-013 din.ready SHALL equal en (combinational); a beat is accepted when din.valid AND din.ready.
REQ-014 Valid and last bits SHALL travel through the pipeline alongside the data; pipeline bubbles SHALL be squeezed only through the global stall.
REQ-015 While dout.valid AND NOT dout.ready, dout.data, dout.valid and dout.last SHALL hold stable.
REQ-016 Bin counter bin[$clog2(FFT_LEN)-1:0] SHALL increment on each accepted beat and wrap from FFT_LEN-1 to 0.
REQ-017 Accepted beats with bin > FFT_LEN/2 SHALL be consumed and discarded, entering no pipeline stage.
REQ-018 Output frame length SHALL be FFT_LEN/2+1 beats (bins 0..FFT_LEN/2 inclusive).
REQ-019 dout.last SHALL be asserted on the beat carrying bin FFT_LEN/2 only.
REQ-020 An accepted din.last with bin == FFT_LEN-1 SHALL be the normal end of frame.
REQ-021 An accepted din.last with bin != FFT_LEN-1 SHALL set frame_err and force bin to 0 on the next cycle.
REQ-022 A misaligned din.last SHALL NOT retroactively assert dout.last.
REQ-023 A din.last arriving before bin FFT_LEN/2 SHALL truncate that output frame without a dout.last.
REQ-024 frame_err SHALL clear only on reset.
REQ-025 Extreme input re = im = -32768 gives 2^31 before the shift; the 33-bit sum SHALL NOT overflow.

Reset
REQ-026 On reset, bin, all stage valid bits, dout.valid, dout.last and frame_err SHALL be 0.
REQ-027 On reset, dout.data SHALL be 0.
REQ-028 din.ready SHALL be 1 during and after reset (en true because dout.valid is 0).
REQ-029 Reset mid-frame SHALL discard all in-flight beats; the next accepted beat is bin 0.

Structure
REQ-030 Constants SHALL live in the shared audio package: AXIS_FFT_W = 32, MAG_W = 24, FFT_LEN_DEFAULT = 1024.
REQ-031 One sub-module, mag_sq_pipe, SHALL hold S1-S3 with an enable input; counter, discard and last logic stay in fft_magnitude.

Verification
REQ-032 FFT_LEN=8, SHIFT=0, dout.ready=1, bins re=k, im=0 for k=0..7 -> 5 outputs 0,1,4,9,16; last on the 5th; each output 3 cycles after its input.
REQ-033 re=im=-32768, SHIFT=8 -> p = 2^23 = 24'h800000; with SHIFT=0 -> 24'hFFFFFF (saturated).
REQ-034 dout.ready low for 4 cycles mid-frame -> dout holds stable; din.ready low; no beat lost or duplicated vs. reference model.
REQ-035 FFT_LEN=8, din.last on bin 3 -> frame_err=1; next beat treated as bin 0; no dout.last for the truncated frame.
REQ-036 Reset asserted with 3 beats in flight -> dout.valid=0 next cycle; frame_err=0; following frame outputs match model from bin 0.
